// File: rtl/mult_fu_scheduler_pkg.sv
// Shared MULT scheduler definitions: per-unit state encoding and default sizing.
package mult_fu_scheduler_pkg;

   typedef enum logic [1:0] {
      MFU_IDLE,
      MFU_BUSY,
      MFU_DONE
   } MULT_FU_STATE;

   localparam int DEF_NUM_FU_MULT = 4;
   localparam int DEF_MULT_LAT    = 4;

endpackage

// File: rtl/rr_multi_select.sv
// Round-robin pick of up to K set bits of req, scanning upward from start_ptr with wrap at N.
// Purely combinational; next_ptr is one past the last pick, or start_ptr when nothing is picked.
module rr_multi_select #(
   parameter int N = 4,
   parameter int K = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] start_ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] next_ptr
);

   always_comb begin
      int          n_gnt;
      logic [PW:0] sum;
      logic [PW-1:0] idx;
      grant    = '0;
      next_ptr = start_ptr;
      n_gnt    = 0;
      sum      = '0;
      idx      = '0;
      for (int off = 0; off < N; off++) begin
         // Wrap explicitly so non-power-of-two N stays in range.
         sum = {1'b0, start_ptr} + (PW+1)'(off);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (req[idx] && (n_gnt < K)) begin
            grant[idx] = 1'b1;
            n_gnt      = n_gnt + 1;
            next_ptr   = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
         end
      end
   end

endmodule

// File: rtl/mult_fu_scheduler.sv
// MULT unit scheduler: offers up to ISSUE_WIDTH idle units round-robin, tracks IDLE/BUSY/DONE per unit.
// Latency: issue -> done after MULT_LAT-1 edges; ack -> grantable next cycle. Done is held until cdb_ack.
module mult_fu_scheduler
   import mult_fu_scheduler_pkg::*;
#(
   parameter int NUM_FU      = DEF_NUM_FU_MULT,
   parameter int ISSUE_WIDTH = 2,
   parameter int MULT_LAT    = DEF_MULT_LAT,
   localparam int PW = $clog2(NUM_FU),
   localparam int CW = $clog2(NUM_FU+1),
   localparam int TW = $clog2(MULT_LAT)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              mispredict,
   input  logic [NUM_FU-1:0] issue_valid,
   input  logic [NUM_FU-1:0] cdb_ack,
   output logic [NUM_FU-1:0] fu_grant,
   output logic [NUM_FU-1:0] done,
   output logic [CW-1:0]     busy_count,
   output logic              issue_err
);

   MULT_FU_STATE      st_q   [NUM_FU];
   MULT_FU_STATE      st_d   [NUM_FU];
   logic [TW-1:0]     cnt_q  [NUM_FU];
   logic [TW-1:0]     cnt_d  [NUM_FU];
   logic [PW-1:0]     rr_q;
   logic [PW-1:0]     take_ptr;
   logic [PW-1:0]     unused_grant_ptr;
   logic [NUM_FU-1:0] idle_mask;
   logic [NUM_FU-1:0] take;
   logic [CW-1:0]     busy_d;

   always_comb begin
      idle_mask = '0;
      done      = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         idle_mask[i] = (st_q[i] == MFU_IDLE);
         done[i]      = (st_q[i] == MFU_DONE);
      end
   end

   // Grants come only from registered state, never from this cycle's inputs.
   rr_multi_select #(.N(NUM_FU), .K(ISSUE_WIDTH)) u_grant_sel (
      .req       (idle_mask),
      .start_ptr (rr_q),
      .grant     (fu_grant),
      .next_ptr  (unused_grant_ptr)
   );

   // Re-scan the accepted subset to find the last taken unit in scan order.
   rr_multi_select #(.N(NUM_FU), .K(ISSUE_WIDTH)) u_take_sel (
      .req       (issue_valid & fu_grant),
      .start_ptr (rr_q),
      .grant     (take),
      .next_ptr  (take_ptr)
   );

   always_comb begin
      busy_d = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         if (mispredict) begin
            st_d[i]  = MFU_IDLE;
            cnt_d[i] = '0;
         end else begin
            case (st_q[i])
               MFU_IDLE: if (take[i]) begin
                  st_d[i]  = MFU_BUSY;
                  cnt_d[i] = TW'(MULT_LAT-1);
               end
               MFU_BUSY: if (cnt_q[i] == TW'(1)) begin
                  st_d[i]  = MFU_DONE;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - TW'(1);
               end
               MFU_DONE: if (cdb_ack[i]) st_d[i] = MFU_IDLE;
               default:  st_d[i] = MFU_IDLE;
            endcase
         end
         if (st_d[i] != MFU_IDLE) busy_d = busy_d + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_FU; i++) begin
            st_q[i]  <= MFU_IDLE;
            cnt_q[i] <= '0;
         end
         rr_q       <= '0;
         busy_count <= '0;
         issue_err  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         if (!mispredict && (|take)) rr_q <= take_ptr;
         busy_count <= busy_d;
         if (|(issue_valid & ~fu_grant)) issue_err <= 1'b1;
      end
   end

endmodule
